// File: rtl/div.sv
// Multi-cycle restoring radix-2 divider with a start/ready handshake to EX.
// The result is {remainder, quotient}, which EX writes to HI and LO.
module div #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      FREE,
      BYZERO,
      ON,
      END
   } state_t;

   state_t             state, state_next;
   logic [CW-1:0]      cnt, cnt_next;
   logic [WIDTH-1:0]   dvd, dvd_next;
   logic [WIDTH-1:0]   dsr, dsr_next;
   logic [WIDTH-1:0]   rem, rem_next;
   logic               neg_q, neg_q_next;
   logic               neg_r, neg_r_next;
   logic [2*WIDTH-1:0] result_next;
   logic               ready_next;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;

   // Register the FSM state, the iteration datapath and the registered outputs.
   // Reset drops everything back to an idle, zeroed divider without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FREE;
         cnt      <= '0;
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         dvd      <= dvd_next;
         dsr      <= dsr_next;
         rem      <= rem_next;
         neg_q    <= neg_q_next;
         neg_r    <= neg_r_next;
         result_o <= result_next;
         ready_o  <= ready_next;
      end
   end

   // Next-state, datapath and output logic. Operands are latched as magnitudes
   // together with the two sign-correction flags, so the ON loop is always unsigned
   // and later changes on the operand inputs cannot affect a running divide.
   // The dividend register doubles as the quotient shift register: each step shifts
   // a dividend bit out into the partial remainder and a quotient bit in at the bottom.
   // A divide-by-zero passes through END once with ready low before raising ready,
   // so its result appears two edges after the start was sampled.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      dvd_next    = dvd;
      dsr_next    = dsr;
      rem_next    = rem;
      neg_q_next  = neg_q;
      neg_r_next  = neg_r;
      result_next = result_o;
      ready_next  = ready_o;
      shifted     = {rem, dvd[WIDTH-1]};
      trial       = shifted - {1'b0, dsr};
      q_fix       = neg_q ? -dvd : dvd;
      r_fix       = neg_r ? -rem : rem;

      case (state)
         FREE: begin
            result_next = '0;
            ready_next  = 1'b0;
            cnt_next    = '0;
            if (start_i && !annul_i) begin
               neg_q_next = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               neg_r_next = signed_div_i && opdata1_i[WIDTH-1];
               dvd_next   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
               dsr_next   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
               rem_next   = '0;
               state_next = (opdata2_i == '0) ? BYZERO : ON;
            end
         end

         BYZERO: begin
            result_next = '0;
            ready_next  = 1'b0;
            if (annul_i || !start_i) begin
               state_next = FREE;
            end else begin
               state_next = END;
            end
         end

         ON: begin
            if (annul_i || !start_i) begin
               state_next  = FREE;
               result_next = '0;
               ready_next  = 1'b0;
            end else if (cnt == CW'(WIDTH)) begin
               result_next = {r_fix, q_fix};
               ready_next  = 1'b1;
               state_next  = END;
            end else begin
               if (!trial[WIDTH]) begin
                  rem_next = trial[WIDTH-1:0];
                  dvd_next = {dvd[WIDTH-2:0], 1'b1};
               end else begin
                  rem_next = shifted[WIDTH-1:0];
                  dvd_next = {dvd[WIDTH-2:0], 1'b0};
               end
               cnt_next = cnt + 1'b1;
            end
         end

         END: begin
            if (!start_i) begin
               state_next  = FREE;
               result_next = '0;
               ready_next  = 1'b0;
            end else begin
               ready_next = 1'b1;
            end
         end

         default: begin
            state_next  = FREE;
            result_next = '0;
            ready_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_div.sv
// Directed testbench for the divider: hand-computed vectors, handshake latency,
// abort via annul, and asynchronous reset in the middle of an operation.
module tb_div;

   logic        clk;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;

   int checks;
   int failures;

   div #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic start, input logic annul);
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      start_i      = start;
      annul_i      = annul;
   endtask

   // Run one divide with start held: check latency from the sampling edge, the
   // result, that it holds while start stays high, and that dropping start clears it.
   // Operands are scrambled right after latching to show they are ignored.
   task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int k;
      @(negedge clk);
      applyStimulus(sgn, a, b, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(~sgn, 32'hDEADBEEF, 32'h0000_0001, 1'b1, 1'b0);
      lat = 0;
      k   = 0;
      while (lat == 0 && k < 40) begin
         k++;
         @(posedge clk);
         #1;
         if (ready_o) lat = k;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({tag, "_result"}, result_o, exp_res);
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_ready"}, {63'b0, ready_o}, 64'd1);
      checkOutput({tag, "_hold_result"}, result_o, exp_res);
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
      checkOutput({tag, "_drop_result"}, result_o, 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      #2 rst = 1'b0;
      #20;
      checkOutput("reset_ready", {63'b0, ready_o}, 64'd0);
      checkOutput("reset_result", result_o, 64'd0);
      #3 rst = 1'b1;

      runDiv("u_100_7",    1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33);
      runDiv("s_m7_2",     1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33);
      runDiv("s_7_m2",     1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33);
      runDiv("s_m100_m7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33);
      runDiv("u_big_16",   1'b0, 32'hFFFFFFFF,   32'h00000010,   64'h0000000F_0FFFFFFF, 33);
      runDiv("s_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33);
      runDiv("u_min_m1",   1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33);
      runDiv("u_byzero",   1'b0, 32'd5,          32'd0,          64'd0,                 2);
      runDiv("s_byzero",   1'b1, 32'd5,          32'd0,          64'd0,                 2);

      // Annul ten cycles into ON, then a fresh 9/3 right after.
      @(negedge clk);
      applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
      @(posedge clk);
      repeat (10) begin
         @(posedge clk);
         #1;
         checkOutput("annul_busy_ready", {63'b0, ready_o}, 64'd0);
      end
      @(negedge clk);
      annul_i = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("annul_ready", {63'b0, ready_o}, 64'd0);
      checkOutput("annul_result", result_o, 64'd0);
      runDiv("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

      // Reset between edges while iterating.
      @(negedge clk);
      applyStimulus(1'b0, 32'd50, 32'd3, 1'b1, 1'b0);
      @(posedge clk);
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checkOutput("rst_on_ready", {63'b0, ready_o}, 64'd0);
      checkOutput("rst_on_result", result_o, 64'd0);
      start_i = 1'b0;
      #10 rst = 1'b1;

      // Reset between edges while a finished result is being held.
      @(negedge clk);
      applyStimulus(1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
      @(posedge clk);
      repeat (33) @(posedge clk);
      #1;
      checkOutput("rst_end_pre_ready", {63'b0, ready_o}, 64'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_end_ready", {63'b0, ready_o}, 64'd0);
      checkOutput("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      #3 rst = 1'b1;

      runDiv("u_12_5", 1'b0, 32'd12, 32'd5, 64'h00000002_00000002, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
